// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if -- serial-in / word-out bundle for uart_rx_cfg.
//   rx           serial line, idle high
//   sample_tick  one-clk pulse at OVERSAMPLE x baud
//   data_valid   one-clk pulse when a frame completes
//   data_out     received word, right-aligned, held
//   parity_err   parity mismatch on last frame, held
//   frame_err    low stop bit on last frame, held
//   break_det    last frame was a line break, held
//   busy         receiver not idle
// Modports: slave = receiver side, master = line driver / word consumer side.
interface uart_rx_cfg_if #(
   parameter int DBITS = 8
);
   logic             rx;
   logic             sample_tick;
   logic             data_valid;
   logic [DBITS-1:0] data_out;
   logic             parity_err;
   logic             frame_err;
   logic             break_det;
   logic             busy;

   modport slave (
      input  rx, sample_tick,
      output data_valid, data_out, parity_err, frame_err, break_det, busy
   );

   modport master (
      output rx, sample_tick,
      input  data_valid, data_out, parity_err, frame_err, break_det, busy
   );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- parametrised UART receiver (oversampled, LSB first).
// Ports:
//   clk_100MHz  system clock
//   reset       asynchronous, active-high
//   bus         uart_rx_cfg_if.slave: rx, sample_tick in; data_valid, data_out,
//               parity_err, frame_err, break_det, busy out
// Parameters: DBITS (5..9), OVERSAMPLE (8..32, even), STOP_BITS (1/2),
//             PARITY (0 none, 1 even, 2 odd).
// Build option: UART_RX_MAJORITY_EN -- data/parity/stop bits are the 2-of-3
//   majority of the last three ticks of the bit; otherwise a single sample
//   at the last tick. The start-bit glitch check is single-sample either way.
module uart_rx_cfg #(
   parameter int DBITS      = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = 0
) (
   input  logic           clk_100MHz,
   input  logic           reset,
   uart_rx_cfg_if.slave   bus
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DBITS);
   localparam logic [TW-1:0] T_MID     = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_END     = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST    = BW'(DBITS - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t           state;
   logic             rx_meta, rx_s;
   logic [TW-1:0]    tick_cnt;
   logic [BW-1:0]    bit_cnt;
   logic             stop_cnt;
   logic [DBITS-1:0] shreg;
   logic             xacc, perr, ferr, zero_run;
   logic             dv_r, perr_r, ferr_r, brk_r, busy_r;
   logic [DBITS-1:0] dout_r;
   logic             bit_s, at_end, brk_now;

   // Two-flop synchroniser; resets to the idle level so reset release
   // cannot look like a start edge.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   localparam logic [TW-1:0] T_M3 = TW'(OVERSAMPLE - 3);
   localparam logic [TW-1:0] T_M2 = TW'(OVERSAMPLE - 2);
   logic maj_a, maj_b, in_bit;

   always_comb in_bit = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         maj_a <= 1'b0;
         maj_b <= 1'b0;
      end else if (bus.sample_tick && in_bit) begin
         if (tick_cnt == T_M3) maj_a <= rx_s;
         if (tick_cnt == T_M2) maj_b <= rx_s;
      end
   end

   always_comb bit_s = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
   always_comb bit_s = rx_s;
`endif

   always_comb begin
      at_end  = bus.sample_tick && (tick_cnt == T_END);
      // Break needs the first stop bit low as well; a second stop bit is not part of it.
      brk_now = zero_run & (stop_cnt | ~bit_s);
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         xacc     <= 1'b0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         zero_run <= 1'b0;
         dv_r     <= 1'b0;
         dout_r   <= '0;
         perr_r   <= 1'b0;
         ferr_r   <= 1'b0;
         brk_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         dv_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state    <= S_START;
                  busy_r   <= 1'b1;
                  tick_cnt <= '0;
               end
            end
            S_START: begin
               if (bus.sample_tick) begin
                  if (tick_cnt == T_MID) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                     end else begin
                        state    <= S_DATA;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        xacc     <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        zero_run <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (at_end) begin
                  tick_cnt <= '0;
                  shreg    <= {bit_s, shreg[DBITS-1:1]};
                  xacc     <= xacc ^ bit_s;
                  zero_run <= zero_run & ~bit_s;
                  if (bit_cnt == B_LAST)
                     state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end else if (bus.sample_tick) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (at_end) begin
                  tick_cnt <= '0;
                  perr     <= (PARITY == 2) ? ~(xacc ^ bit_s) : (xacc ^ bit_s);
                  zero_run <= zero_run & ~bit_s;
                  state    <= S_STOP;
               end else if (bus.sample_tick) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (at_end) begin
                  tick_cnt <= '0;
                  if (stop_cnt == LAST_STOP) begin
                     // Returning to IDLE at mid-stop lets a back-to-back start edge be seen.
                     dv_r   <= 1'b1;
                     dout_r <= shreg;
                     perr_r <= perr;
                     ferr_r <= ferr | ~bit_s;
                     brk_r  <= brk_now;
                     state  <= brk_now ? S_BREAK : S_IDLE;
                     busy_r <= brk_now;
                  end else begin
                     stop_cnt <= 1'b1;
                     ferr     <= ferr | ~bit_s;
                     zero_run <= brk_now;
                  end
               end else if (bus.sample_tick) begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_BREAK: begin
               if (rx_s) begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus.data_valid = dv_r;
      bus.data_out   = dout_r;
      bus.parity_err = perr_r;
      bus.frame_err  = ferr_r;
      bus.break_det  = brk_r;
      bus.busy       = busy_r;
   end
endmodule
